// File: rtl/timer_pkg.sv
// Shared state encoding, digit limits and the 6-digit BCD layout for the countdown timer.
// Latency: none, types and constants only.
// Backpressure: not applicable.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   localparam logic [3:0] DIG_MAX_DEC = 4'd9;
   localparam logic [3:0] DIG_MAX_SEX = 4'd5;

   // MM:SS.cc, most significant digit first; maps onto hex5..hex0
   typedef struct packed {
      logic [3:0] min_h;
      logic [3:0] min_l;
      logic [3:0] sec_h;
      logic [3:0] sec_l;
      logic [3:0] cs_h;
      logic [3:0] cs_l;
   } bcd6_t;

   function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_val);
      return (d > max_val) ? max_val : d;
   endfunction

endpackage

// File: rtl/countdown_digit.sv
// One BCD digit of the countdown chain; wraps 0 -> MAX and borrows from the next digit up.
// Latency: value updates on the edge after load/dec_en; borrow_out is combinational.
// Backpressure: none, enables are single-cycle qualifiers.
module countdown_digit
   import timer_pkg::*;
#(
   parameter logic [3:0] MAX = DIG_MAX_DEC
) (
   input  logic       CLOCK_50,
   input  logic       key_reset,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec_en,
   output logic [3:0] value,
   output logic       borrow_out
);

   assign borrow_out = dec_en && (value == 4'd0);

   always_ff @(posedge CLOCK_50) begin
      if (key_reset)
         value <= 4'd0;
      else if (load)
         value <= load_val;
      else if (dec_en)
         value <= borrow_out ? MAX : value - 4'd1;
   end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS.cc countdown timer with alarm; COUNTDOWN_ALARM_BLINK_EN makes the alarm blink.
// Latency: load/start_pause act on the next edge; first decrement CLK_DIV cycles after start.
// Backpressure: none, control inputs are debounced single-cycle pulses.
module countdown_timer
   import timer_pkg::*;
#(
   parameter int CLK_DIV     = 500000,
   parameter int BLINK_TICKS = 50
) (
   input  logic        CLOCK_50,
   input  logic        key_reset,
   input  logic        load,
   input  logic        start_pause,
   input  logic [15:0] preset,
   output bcd6_t       digits,
   output logic        running,
   output logic        expired,
   output logic        alarm
);

   localparam int            PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

   if (CLK_DIV < 2 || BLINK_TICKS < 1) begin : g_param_check
      $error("countdown_timer: CLK_DIV must be >= 2 and BLINK_TICKS >= 1");
   end

   state_t        state, state_n;
   logic [PW-1:0] prescaler;
   logic          counting, tick, dec, at_one;
   bcd6_t         load_val;
   logic [5:0]    borrow;

   assign counting = (state == RUNNING) || (state == EXPIRED);
   assign tick     = counting && (prescaler == PRE_MAX);
   assign dec      = tick && (state == RUNNING);
   // Decrementing 00:00.01 is the only way to land on zero
   assign at_one   = (digits == 24'h000001);

   always_comb begin
      load_val       = '0;
      load_val.min_h = clamp_digit(preset[15:12], DIG_MAX_DEC);
      load_val.min_l = clamp_digit(preset[11:8],  DIG_MAX_DEC);
      load_val.sec_h = clamp_digit(preset[7:4],   DIG_MAX_SEX);
      load_val.sec_l = clamp_digit(preset[3:0],   DIG_MAX_DEC);
   end

   always_ff @(posedge CLOCK_50) begin
      if (key_reset) begin
         state     <= IDLE;
         prescaler <= '0;
      end else begin
         state <= state_n;
         if (load)
            prescaler <= '0;
         else if (counting)
            prescaler <= (prescaler == PRE_MAX) ? '0 : prescaler + PW'(1);
      end
   end

   always_comb begin
      state_n = state;
      running = (state == RUNNING);
      expired = (state == EXPIRED);
      case (state)
         IDLE:    if (start_pause && digits != '0) state_n = RUNNING;
         RUNNING: begin
            // Reaching zero wins over a simultaneous pause request
            if (dec && at_one)
               state_n = EXPIRED;
            else if (start_pause)
               state_n = PAUSED;
         end
         PAUSED:  if (start_pause) state_n = RUNNING;
         EXPIRED: state_n = EXPIRED;
         default: state_n = IDLE;
      endcase
      if (load)
         state_n = IDLE;
   end

   countdown_digit #(.MAX(DIG_MAX_DEC)) u_cs_l (
      .CLOCK_50(CLOCK_50), .key_reset(key_reset), .load(load), .load_val(load_val.cs_l),
      .dec_en(dec), .value(digits.cs_l), .borrow_out(borrow[0])
   );
   countdown_digit #(.MAX(DIG_MAX_DEC)) u_cs_h (
      .CLOCK_50(CLOCK_50), .key_reset(key_reset), .load(load), .load_val(load_val.cs_h),
      .dec_en(borrow[0]), .value(digits.cs_h), .borrow_out(borrow[1])
   );
   countdown_digit #(.MAX(DIG_MAX_DEC)) u_sec_l (
      .CLOCK_50(CLOCK_50), .key_reset(key_reset), .load(load), .load_val(load_val.sec_l),
      .dec_en(borrow[1]), .value(digits.sec_l), .borrow_out(borrow[2])
   );
   countdown_digit #(.MAX(DIG_MAX_SEX)) u_sec_h (
      .CLOCK_50(CLOCK_50), .key_reset(key_reset), .load(load), .load_val(load_val.sec_h),
      .dec_en(borrow[2]), .value(digits.sec_h), .borrow_out(borrow[3])
   );
   countdown_digit #(.MAX(DIG_MAX_DEC)) u_min_l (
      .CLOCK_50(CLOCK_50), .key_reset(key_reset), .load(load), .load_val(load_val.min_l),
      .dec_en(borrow[3]), .value(digits.min_l), .borrow_out(borrow[4])
   );
   countdown_digit #(.MAX(DIG_MAX_DEC)) u_min_h (
      .CLOCK_50(CLOCK_50), .key_reset(key_reset), .load(load), .load_val(load_val.min_h),
      .dec_en(borrow[4]), .value(digits.min_h), .borrow_out(borrow[5])
   );

   // Zero is caught before the chain could ever underflow the top digit
   min_h_never_borrows: assert property (@(posedge CLOCK_50) disable iff (key_reset) !borrow[5]);

`ifdef COUNTDOWN_ALARM_BLINK_EN
   localparam int            BW        = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

   logic [BW-1:0] blink_cnt;
   logic          alarm_q;

   always_ff @(posedge CLOCK_50) begin
      if (key_reset || state_n != EXPIRED) begin
         blink_cnt <= '0;
         alarm_q   <= 1'b0;
      end else if (state != EXPIRED) begin
         blink_cnt <= '0;
         alarm_q   <= 1'b1;
      end else if (tick) begin
         if (blink_cnt == BLINK_MAX) begin
            blink_cnt <= '0;
            alarm_q   <= ~alarm_q;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end
   end

   assign alarm = alarm_q;
`else
   assign alarm = expired;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with CLK_DIV=4, BLINK_TICKS=2.
// Inputs change and outputs are sampled on the falling edge.
module tb_countdown_timer;

   logic        CLOCK_50 = 1'b0;
   logic        key_reset;
   logic        load;
   logic        start_pause;
   logic [15:0] preset;
   logic [23:0] digits;
   logic        running;
   logic        expired;
   logic        alarm;

   int checks = 0;
   int errors = 0;

`ifdef COUNTDOWN_ALARM_BLINK_EN
   localparam logic BLINK = 1'b1;
`else
   localparam logic BLINK = 1'b0;
`endif

   countdown_timer #(.CLK_DIV(4), .BLINK_TICKS(2)) dut (
      .CLOCK_50   (CLOCK_50),
      .key_reset  (key_reset),
      .load       (load),
      .start_pause(start_pause),
      .preset     (preset),
      .digits     (digits),
      .running    (running),
      .expired    (expired),
      .alarm      (alarm)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   task automatic pulse(input logic ld, input logic sp);
      load        = ld;
      start_pause = sp;
      @(negedge CLOCK_50);
      load        = 1'b0;
      start_pause = 1'b0;
   endtask

   initial begin
      key_reset   = 1'b1;
      load        = 1'b0;
      start_pause = 1'b0;
      preset      = 16'h0000;
      wait_cycles(3);
      check("rst_digits",  {8'h0, digits}, 32'h0);
      check("rst_running", {31'h0, running}, 32'h0);
      check("rst_expired", {31'h0, expired}, 32'h0);
      check("rst_alarm",   {31'h0, alarm}, 32'h0);
      key_reset = 1'b0;

      // start_pause with zero digits is ignored
      pulse(1'b0, 1'b1);
      check("zero_start_running", {31'h0, running}, 32'h0);
      check("zero_start_digits",  {8'h0, digits}, 32'h0);

      // 10:00 -> borrow through every digit
      preset = 16'h1000;
      pulse(1'b1, 1'b0);
      check("load_1000", {8'h0, digits}, 32'h100000);
      pulse(1'b0, 1'b1);
      check("start_running", {31'h0, running}, 32'h1);
      wait_cycles(3);
      check("before_first_tick", {8'h0, digits}, 32'h100000);
      wait_cycles(1);
      check("borrow_all", {8'h0, digits}, 32'h095999);
      wait_cycles(4);
      check("second_tick", {8'h0, digits}, 32'h095998);

      // Pause with prescaler advancing to 1, resume needs 3 more cycles
      pulse(1'b0, 1'b1);
      check("pause_running", {31'h0, running}, 32'h0);
      wait_cycles(20);
      check("paused_digits",  {8'h0, digits}, 32'h095998);
      check("paused_running", {31'h0, running}, 32'h0);
      pulse(1'b0, 1'b1);
      check("resume_running", {31'h0, running}, 32'h1);
      wait_cycles(2);
      check("resume_no_tick", {8'h0, digits}, 32'h095998);
      wait_cycles(1);
      check("resume_tick", {8'h0, digits}, 32'h095997);

      // Load and start together from RUNNING: load wins, preset clamped
      preset = 16'hFF7F;
      pulse(1'b1, 1'b1);
      check("clamp_digits",  {8'h0, digits}, 32'h995900);
      check("clamp_running", {31'h0, running}, 32'h0);
      check("clamp_expired", {31'h0, expired}, 32'h0);
      pulse(1'b0, 1'b1);
      check("max_start", {31'h0, running}, 32'h1);
      wait_cycles(3);
      check("max_before_tick", {8'h0, digits}, 32'h995900);
      wait_cycles(1);
      check("max_first_tick", {8'h0, digits}, 32'h995899);

      // 00:01 runs out after 100 ticks
      preset = 16'h0001;
      pulse(1'b1, 1'b0);
      check("load_0001", {8'h0, digits}, 32'h000100);
      pulse(1'b0, 1'b1);
      wait_cycles(4);
      check("cs_wrap", {8'h0, digits}, 32'h000099);
      wait_cycles(392);
      check("last_cs",         {8'h0, digits}, 32'h000001);
      check("last_cs_running", {31'h0, running}, 32'h1);
      wait_cycles(3);
      check("last_cs_hold", {8'h0, digits}, 32'h000001);
      wait_cycles(1);
      check("expire_digits",  {8'h0, digits}, 32'h0);
      check("expire_expired", {31'h0, expired}, 32'h1);
      check("expire_running", {31'h0, running}, 32'h0);
      check("expire_alarm",   {31'h0, alarm}, 32'h1);
      wait_cycles(7);
      check("alarm_7", {31'h0, alarm}, 32'h1);
      wait_cycles(1);
      check("alarm_8", {31'h0, alarm}, {31'h0, ~BLINK});
      wait_cycles(8);
      check("alarm_16", {31'h0, alarm}, 32'h1);

      pulse(1'b0, 1'b1);
      check("expired_ignore_start", {31'h0, expired}, 32'h1);
      check("expired_no_run",       {31'h0, running}, 32'h0);

      // Reset mid-EXPIRED
      key_reset = 1'b1;
      wait_cycles(1);
      check("rst2_expired", {31'h0, expired}, 32'h0);
      check("rst2_alarm",   {31'h0, alarm}, 32'h0);
      check("rst2_running", {31'h0, running}, 32'h0);
      check("rst2_digits",  {8'h0, digits}, 32'h0);
      key_reset = 1'b0;
      wait_cycles(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Count-down timer; the downward counterpart of the team's up-counting stopwatch.
- Loads a preset of MM:SS and counts down in 10 ms (centisecond) steps to 00:00.00, then raises an alarm.
- Sits between the debounced key/switch front end and the sevenseg display drivers.
- Output digits map one-per-display onto hex5..hex0.

Parameters:
- CLK_DIV, 500000: CLOCK_50 cycles per 10 ms tick (100 Hz from 50 MHz).
- BLINK_TICKS, 50: ticks per alarm toggle when blink is compiled in (0.5 s).

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- key_reset  in  1  synchronous, active-high reset.
- load  in  1  one-cycle pulse (already debounced); load preset, go IDLE.
- start_pause  in  1  one-cycle pulse (already debounced); toggles run/pause.
- preset  in  16  BCD {min_h, min_l, sec_h, sec_l}.
- digits  out  24  BCD {min_h, min_l, sec_h, sec_l, cs_h, cs_l}; registered.
- running  out  1  high in RUNNING.
- expired  out  1  high in EXPIRED.
- alarm  out  1  alarm LED drive.

Behaviour:
- Reset: state=IDLE, digits=0, prescaler=0, running=0, expired=0, alarm=0. Reset has priority over every other input.
- States and transitions:
  - IDLE: on start_pause with digits!=0, go to RUNNING. If digits==0, start_pause is ignored.
  - RUNNING: on start_pause, go to PAUSED. On a tick, decrement digits. If the decremented value is 0, go to EXPIRED on the same edge.
  - PAUSED: on start_pause, go to RUNNING. digits and prescaler are frozen.
  - EXPIRED: start_pause is ignored. Only load or reset leaves this state.
- Load:
  - Accepted in any state; next state is IDLE.
  - digits <= {preset, 8'h00}; prescaler cleared.
  - Takes effect on the edge after the pulse.
- Load and start_pause in the same cycle: load wins and start_pause is dropped.
- Preset clamping, per digit at load time:
  - min_h, min_l, sec_l: any value >9 clamps to 9.
  - sec_h: any value >5 clamps to 5.
- Prescaler:
  - Counts 0..CLK_DIV-1 while in RUNNING or EXPIRED; holds otherwise.
  - A tick is the cycle in which prescaler==CLK_DIV-1; prescaler then wraps to 0.
  - First decrement occurs CLK_DIV cycles after the start_pause edge from IDLE with a cleared prescaler.
  - Resume from PAUSED continues from the held prescaler value.
- Decrement (BCD borrow chain, all in one cycle):
  - cs_l 0→9 borrows from cs_h.
  - cs_h 0→9 borrows from sec_l.
  - sec_l 0→9 borrows from sec_h.
  - sec_h 0→5 borrows from min_l.
  - min_l 0→9 borrows from min_h.
  - min_h: a borrow is never required, because zero is detected first.
  - No digit ever holds a value outside its range.
- Extremes: 99:59.99 is the maximum; 00:00.01 reaches 0 after one tick and asserts expired.
- Outputs:
  - running and expired are decoded from the registered state.
  - alarm = expired unless the optional feature below is compiled in.

Optional Feature:
- Macro: COUNTDOWN_ALARM_BLINK_EN.
- Defined:
  - alarm starts at 1 on entry to EXPIRED.
  - A tick counter 0..BLINK_TICKS-1 runs in EXPIRED; alarm toggles when it wraps.
  - Counter and alarm clear on leaving EXPIRED.
- Undefined: alarm is steady high in EXPIRED, and the blink counter is not synthesised.

Decomposition:
- Package timer_pkg:
  - state enum {IDLE, RUNNING, PAUSED, EXPIRED}.
  - Digit-max constants DIG_MAX_DEC=9 and DIG_MAX_SEX=5.
  - Packed 6-digit BCD type with its field layout.
- Sub-module countdown_digit:
  - One 4-bit BCD digit with parameter MAX.
  - Inputs: load, load value, decrement enable (borrow-in).
  - Output: borrow-out, asserted when digit==0 and enabled; wraps to MAX.
  - Instantiated six times as a chain.

Test Plan (all with CLK_DIV=4):
1. Reset → digits=0, state IDLE, running/expired/alarm all 0. start_pause with digits=0 → stays IDLE.
2. Load preset=16'h0001, then start_pause → after 4 cycles digits=00:00.99; after 100 ticks digits=00:00.00, expired=1, running=0.
3. Load 16'h1000, start, run 1 tick → digits=09:59.99, confirming the borrow across every digit.
4. Run, start_pause (pause) for 20 cycles → digits and prescaler frozen. Resume → next tick lands exactly (4 − held prescaler) cycles later.
5. Load and start_pause in the same cycle with preset=16'hFF7F → state IDLE, digits=99:59.00 (clamped), running=0.
6. Load 16'h0000 → expired state reached via a preset of 00:00.01 equivalent (load 16'h0001, expire):
   - Without the macro: alarm is steady 1.
   - With COUNTDOWN_ALARM_BLINK_EN and BLINK_TICKS=2: alarm toggles every 8 cycles.
   - key_reset mid-EXPIRED → all outputs 0 on the next edge.
